host_sram_responder: RTL and testbench

//   Synthesizable responder for the 16-bit host request bus (h_addr/h_wr_en/h_bytesel/
//   h_wdata -> h_rdata/h_compl). Drop-in stand-in for the SDRAM controller's host side:

---
 rtl/host_sram_responder.sv | 134 +++++++++++++
 tb/tb_host_sram_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/host_sram_responder.sv
// Host-bus SRAM responder: on-chip RAM behind the 16-bit host request bus with programmable
// wait states and a post-reset init-done strobe. Define HOST_SRAM_CLEAR_EN to zero the RAM during INIT.
module host_sram_responder #(
  parameter int ADDR_BITS   = 16,
  parameter int INIT_CYCLES = 8,
  parameter int WR_LATENCY  = 2,
  parameter int RD_LATENCY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] h_addr,
  input  logic        h_wr_en,
  input  logic [1:0]  h_bytesel,
  input  logic [15:0] h_wdata,
  output logic [15:0] h_rdata,
  output logic        h_compl
);

  localparam int WORD_BITS = ADDR_BITS - 1;
  localparam int DEPTH     = 1 << WORD_BITS;
  localparam int LAT_MAX   = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
  localparam int LAT_W     = $clog2(LAT_MAX + 1);
`ifdef HOST_SRAM_CLEAR_EN
  localparam int INIT_W    = WORD_BITS;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEPTH - 1);
`else
  localparam int INIT_W    = $clog2(INIT_CYCLES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_ACK} state_e;

  state_e                 r_state, w_state_nxt;
  logic [INIT_W-1:0]      r_init_cnt;
  logic [LAT_W-1:0]       r_lat_cnt;
  logic [WORD_BITS-1:0]   r_idx;
  logic                   r_wr_en;
  logic [1:0]             r_be;
  logic [15:0]            r_wdata;
  logic [15:0]            r_rdata;
  logic                   r_compl;
  logic [15:0]            r_mem [DEPTH];

  logic                   w_capture, w_access, w_init_done;
  logic [1:0]             w_mem_we;
  logic [WORD_BITS-1:0]   w_mem_idx;
  logic [15:0]            w_mem_wdata;
  logic [15:0]            w_rd_word;
  logic                   w_unused_addr;

  assign w_unused_addr = ^{h_addr[31:ADDR_BITS], h_addr[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    w_init_done = 1'b0;
    unique case (r_state)
      S_INIT: if (r_init_cnt == INIT_LAST) begin
        w_init_done = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_IDLE: if (h_bytesel != 2'b00) begin
        w_capture   = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: if (r_lat_cnt == '0) begin
        w_access    = 1'b1;
        w_state_nxt = S_ACK;
      end
      S_ACK:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign w_rd_word = r_mem[r_idx];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt <= '0;
      r_lat_cnt  <= '0;
      r_idx      <= '0;
      r_wr_en    <= 1'b0;
      r_be       <= 2'b00;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_compl    <= 1'b0;
    end else begin
      r_compl <= w_init_done | w_access;
      r_rdata <= (w_access && !r_wr_en) ? w_rd_word : 16'h0000;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (w_capture) begin
        r_idx     <= h_addr[ADDR_BITS-1:1];
        r_wr_en   <= h_wr_en;
        r_be      <= h_bytesel;
        r_wdata   <= h_wdata;
        r_lat_cnt <= h_wr_en ? LAT_W'(WR_LATENCY - 1) : LAT_W'(RD_LATENCY - 1);
      end else if (r_state == S_BUSY && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
    end
  end

  // Write port is shared between the host access and, in the clearing build, the INIT sweep.
  always_comb begin
    w_mem_we    = (w_access && r_wr_en) ? r_be : 2'b00;
    w_mem_idx   = r_idx;
    w_mem_wdata = r_wdata;
`ifdef HOST_SRAM_CLEAR_EN
    if (r_state == S_INIT && rst_n) begin
      w_mem_we    = 2'b11;
      w_mem_idx   = r_init_cnt;
      w_mem_wdata = 16'h0000;
    end
`endif
  end

  // NOTE: the RAM array has no reset; contents survive rst_n and only explicit writes change them.
  always_ff @(posedge clk) begin
    if (w_mem_we[0]) r_mem[w_mem_idx][7:0]  <= w_mem_wdata[7:0];
    if (w_mem_we[1]) r_mem[w_mem_idx][15:8] <= w_mem_wdata[15:8];
  end

  assign h_rdata = r_rdata;
  assign h_compl = r_compl;

endmodule

// File: tb/tb_host_sram_responder.sv
// Directed bench for host_sram_responder: init pulse, table of write/read vectors,
// held-request throughput and reset abandoning a pending write.
module tb_host_sram_responder;

`ifdef HOST_SRAM_CLEAR_EN
  localparam int INIT_LEN = 32768;
  localparam bit CLEARING = 1'b1;
`else
  localparam int INIT_LEN = 8;
  localparam bit CLEARING = 1'b0;
`endif
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] h_addr;
  logic        h_wr_en;
  logic [1:0]  h_bytesel;
  logic [15:0] h_wdata;
  logic [15:0] h_rdata;
  logic        h_compl;

  int n_vec  = 0;
  int n_miss = 0;

  host_sram_responder #(
    .ADDR_BITS(16), .INIT_CYCLES(8), .WR_LATENCY(WR_LAT), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_addr(h_addr), .h_wr_en(h_wr_en),
    .h_bytesel(h_bytesel), .h_wdata(h_wdata), .h_rdata(h_rdata), .h_compl(h_compl)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns posedges counted until h_compl is seen high (bound+1 on timeout).
  task automatic wait_compl(input int bound, output int n, output logic [15:0] rd);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!h_compl && n <= bound);
    rd = h_rdata;
  endtask

  // Called at a negedge; issues one request, scrambles the bus while busy, ends in the cycle after ACK.
  task automatic run_req(input string name, input logic [31:0] addr, input logic wr,
                         input logic [1:0] be, input logic [15:0] wdata,
                         input int exp_lat, input bit chk_rd, input logic [15:0] exp_rd);
    int          lat;
    logic [15:0] rd;
    h_addr = addr; h_wr_en = wr; h_bytesel = be; h_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    h_bytesel = 2'b00; h_addr = 32'h0000_0F00; h_wr_en = ~wr; h_wdata = 16'h6666;
    wait_compl(20, lat, rd);
    check({name, " latency"}, lat, exp_lat);
    if (chk_rd) check({name, " rdata"}, rd, exp_rd);
    @(posedge clk);
    @(negedge clk);
    check({name, " strobe width"}, h_compl, 1'b0);
    check({name, " rdata cleared"}, h_rdata, 16'h0000);
  endtask

  vec_t vecs[$];

  initial begin
    int          n;
    int          gap;
    int          extra;
    logic [15:0] rd;

    vecs.push_back('{"wr 0010",        32'h0000_0010, 1'b1, 2'b11, 16'h1234, 16'h0000, WR_LAT});
    vecs.push_back('{"rd 0010",        32'h0000_0010, 1'b0, 2'b11, 16'h0000, 16'h1234, RD_LAT});
    vecs.push_back('{"wr 0020 full",   32'h0000_0020, 1'b1, 2'b11, 16'hAAAA, 16'h0000, WR_LAT});
    vecs.push_back('{"wr 0020 lo",     32'h0000_0020, 1'b1, 2'b01, 16'h5555, 16'h0000, WR_LAT});
    vecs.push_back('{"rd 0020 a",      32'h0000_0020, 1'b0, 2'b01, 16'h0000, 16'hAA55, RD_LAT});
    vecs.push_back('{"wr 0020 hi",     32'h0000_0020, 1'b1, 2'b10, 16'h0F0F, 16'h0000, WR_LAT});
    vecs.push_back('{"rd 0020 b",      32'h0000_0020, 1'b0, 2'b10, 16'h0000, 16'h0F55, RD_LAT});
    vecs.push_back('{"wr 1FFFE",       32'h0001_FFFE, 1'b1, 2'b11, 16'hBEEF, 16'h0000, WR_LAT});
    vecs.push_back('{"rd FFFE alias",  32'h0000_FFFE, 1'b0, 2'b11, 16'h0000, 16'hBEEF, RD_LAT});
    vecs.push_back('{"rd FFFF bit0",   32'h0000_FFFF, 1'b0, 2'b11, 16'h0000, 16'hBEEF, RD_LAT});
    vecs.push_back('{"rd 0011 bit0",   32'h0000_0011, 1'b0, 2'b11, 16'h0000, 16'h1234, RD_LAT});
    vecs.push_back('{"wr FFFF0012",    32'hFFFF_0012, 1'b1, 2'b11, 16'hC3C3, 16'h0000, WR_LAT});
    vecs.push_back('{"rd 0012 wrap",   32'h0000_0012, 1'b0, 2'b11, 16'h0000, 16'hC3C3, RD_LAT});

    // Reset state, with a request held on the bus that INIT must ignore.
    rst_n = 1'b0; h_addr = 32'h10; h_wr_en = 1'b0; h_bytesel = 2'b11; h_wdata = 16'h0;
    repeat (3) @(negedge clk);
    check("reset compl", h_compl, 1'b0);
    check("reset rdata", h_rdata, 16'h0000);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 3) h_bytesel = 2'b00;
    end while (!h_compl && n <= INIT_LEN + 10);
    check("init pulse delay", n, INIT_LEN);
    check("init pulse rdata", h_rdata, 16'h0000);
    extra = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (h_compl) extra++;
    end
    check("no compl after init", extra, 0);

    // bytesel=00 with write enabled is not a request.
    h_addr = 32'h10; h_wr_en = 1'b1; h_wdata = 16'hFFFF; h_bytesel = 2'b00;
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (h_compl) extra++;
    end
    check("bytesel 00 ignored", extra, 0);

    foreach (vecs[i])
      run_req(vecs[i].name, vecs[i].addr, vecs[i].wr, vecs[i].be, vecs[i].wdata,
              vecs[i].exp_lat, !vecs[i].wr, vecs[i].exp_rdata);
    run_req("rd 0010 after 00", 32'h10, 1'b0, 2'b11, 16'h0, RD_LAT, 1'b1, 16'h1234);

    // Request held through ACK: the ACK-cycle edge must not capture, leaving LAT+1 low cycles.
    h_addr = 32'h10; h_wr_en = 1'b0; h_bytesel = 2'b11;
    @(posedge clk);
    @(negedge clk);
    wait_compl(20, n, rd);
    check("held rd latency", n, RD_LAT);
    check("held rd rdata", rd, 16'h1234);
    gap = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      if (!h_compl) gap++;
    end while (!h_compl && gap <= 20);
    check("held low cycles between strobes", gap, RD_LAT + 1);
    check("held second rdata", h_rdata, 16'h1234);
    h_bytesel = 2'b00;
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (h_compl) extra++;
    end
    check("held no third compl", extra, 0);

    // Reset mid-BUSY abandons the pending write and restarts INIT.
    run_req("wr 0040", 32'h40, 1'b1, 2'b11, 16'h55AA, WR_LAT, 1'b0, 16'h0);
    h_addr = 32'h40; h_wr_en = 1'b1; h_bytesel = 2'b11; h_wdata = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    h_bytesel = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midbusy reset compl", h_compl, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_compl(INIT_LEN + 10, n, rd);
    check("reinit pulse delay", n, INIT_LEN);
    check("reinit pulse rdata", rd, 16'h0000);
    @(negedge clk);
    run_req("rd 0040 after reset", 32'h40, 1'b0, 2'b11, 16'h0, RD_LAT, 1'b1,
            CLEARING ? 16'h0000 : 16'h55AA);
    run_req("rd 0010 after reset", 32'h10, 1'b0, 2'b11, 16'h0, RD_LAT, 1'b1,
            CLEARING ? 16'h0000 : 16'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
